// File: rtl/if_id_reg.sv
// IF/ID pipeline register: one-cycle boundary between fetch and decode.
// Carries instruction, PC, PC+4, the fetch exception code and the delay-slot flag.
// Per edge, flush takes priority over a stall (Enable=0), and a stall over capture.
// A two-state EMPTY/FULL machine provides the valid bit.
// Optional performance counters (stalled cycles, flushes) are compiled in only
// when the macro IFID_PERF_EN is defined.
module if_id_reg #(
  parameter logic [31:0] RESET_PC = 32'h00003000
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        Enable,
  input  logic        Flush,
  input  logic [31:0] Instr_In,
  input  logic [31:0] PC_In,
  input  logic [31:0] PC4_In,
  input  logic        IF_Error_In,
  input  logic        BD_In,
  output logic [31:0] Instr_Out,
  output logic [31:0] PC_Out,
  output logic [31:0] PC4_Out,
  output logic [4:0]  ExcCode_Out,
  output logic        BD_Out,
`ifdef IFID_PERF_EN
  output logic        Valid_Out,
  output logic [31:0] Stall_Cnt,
  output logic [31:0] Flush_Cnt
`else
  output logic        Valid_Out
`endif
);

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // A fetch error surfaces as an address-error-on-load exception in ID.
  function automatic logic [4:0] fetch_exc(input logic if_err);
    return if_err ? EXC_ADEL : EXC_NONE;
  endfunction

  // Counters stop at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
    return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
  endfunction

  state_t      state_p1;
  state_t      state_nxt;
  logic [31:0] instr_p1;
  logic [31:0] pc_p1;
  logic [31:0] pc4_p1;
  logic [4:0]  exc_p1;
  logic        bd_p1;

  // ---- stage boundary: IF -> p1 (ID side) ----

  // Valid-state register; reset leaves the register holding a bubble.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_p1 <= EMPTY;
    end else begin
      state_p1 <= state_nxt;
    end
  end

  // Next state: flush empties, capture fills, stall keeps the current state.
  always_comb begin
    state_nxt = state_p1;
    if (Flush) begin
      state_nxt = EMPTY;
    end else if (Enable) begin
      state_nxt = FULL;
    end
  end

  // Payload register: a flush keeps the PC so exception/redirect logic still sees it.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      instr_p1 <= 32'h0000_0000;
      pc_p1    <= RESET_PC;
      pc4_p1   <= RESET_PC + 32'd4;
      exc_p1   <= EXC_NONE;
      bd_p1    <= 1'b0;
    end else if (Flush) begin
      instr_p1 <= 32'h0000_0000;
      pc_p1    <= PC_In;
      pc4_p1   <= PC4_In;
      exc_p1   <= EXC_NONE;
      bd_p1    <= 1'b0;
    end else if (Enable) begin
      instr_p1 <= Instr_In;
      pc_p1    <= PC_In;
      pc4_p1   <= PC4_In;
      exc_p1   <= fetch_exc(IF_Error_In);
      bd_p1    <= BD_In;
    end
  end

`ifdef IFID_PERF_EN
  logic [31:0] stall_cnt_p1;
  logic [31:0] flush_cnt_p1;

  // Stalled cycles count only while a real instruction is held.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      stall_cnt_p1 <= 32'h0;
    end else if (!Flush && !Enable && (state_p1 == FULL)) begin
      stall_cnt_p1 <= sat_inc(stall_cnt_p1);
    end
  end

  // Every flush edge counts, whether or not the register was stalled.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      flush_cnt_p1 <= 32'h0;
    end else if (Flush) begin
      flush_cnt_p1 <= sat_inc(flush_cnt_p1);
    end
  end

  assign Stall_Cnt = stall_cnt_p1;
  assign Flush_Cnt = flush_cnt_p1;
`endif

  assign Instr_Out   = instr_p1;
  assign PC_Out      = pc_p1;
  assign PC4_Out     = pc4_p1;
  assign ExcCode_Out = exc_p1;
  assign BD_Out      = bd_p1;
  assign Valid_Out   = (state_p1 == FULL);

endmodule

// File: tb/tb_if_id_reg.sv
// Self-checking bench for if_id_reg: directed vectors, a record-level reference
// model compared on every falling edge, and literal expectations at key points.
module tb_if_id_reg;

  localparam logic [31:0] RPC = 32'h00003000;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        Enable;
  logic        Flush;
  logic [31:0] Instr_In;
  logic [31:0] PC_In;
  logic [31:0] PC4_In;
  logic        IF_Error_In;
  logic        BD_In;
  logic [31:0] Instr_Out;
  logic [31:0] PC_Out;
  logic [31:0] PC4_Out;
  logic [4:0]  ExcCode_Out;
  logic        BD_Out;
  logic        Valid_Out;
`ifdef IFID_PERF_EN
  logic [31:0] Stall_Cnt;
  logic [31:0] Flush_Cnt;
`endif

  int errors = 0;
  int checks = 0;

  if_id_reg #(.RESET_PC(RPC)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Enable(Enable), .Flush(Flush),
    .Instr_In(Instr_In), .PC_In(PC_In), .PC4_In(PC4_In),
    .IF_Error_In(IF_Error_In), .BD_In(BD_In),
    .Instr_Out(Instr_Out), .PC_Out(PC_Out), .PC4_Out(PC4_Out),
    .ExcCode_Out(ExcCode_Out), .BD_Out(BD_Out),
`ifdef IFID_PERF_EN
    .Valid_Out(Valid_Out), .Stall_Cnt(Stall_Cnt), .Flush_Cnt(Flush_Cnt)
`else
    .Valid_Out(Valid_Out)
`endif
  );

  always #5 Clock = ~Clock;

  // Reference model: what the register must hold, as a record.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [4:0]  exc;
    logic        bd;
    logic        valid;
  } rec_t;

  rec_t    m;
  longint  m_stall;
  longint  m_flush;
  bit      m_ready = 0;

  always @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      m = '{instr: 32'h0, pc: RPC, pc4: RPC + 32'd4, exc: 5'd0, bd: 1'b0, valid: 1'b0};
      m_stall = 0;
      m_flush = 0;
      m_ready = 1;
    end else if (Flush) begin
      m = '{instr: 32'h0, pc: PC_In, pc4: PC4_In, exc: 5'd0, bd: 1'b0, valid: 1'b0};
      if (m_flush < 64'hFFFF_FFFF) m_flush = m_flush + 1;
    end else if (!Enable) begin
      if (m.valid && m_stall < 64'hFFFF_FFFF) m_stall = m_stall + 1;
    end else begin
      m = '{instr: Instr_In, pc: PC_In, pc4: PC4_In,
            exc: (IF_Error_In ? 5'd4 : 5'd0), bd: BD_In, valid: 1'b1};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model away from the active edge.
  always @(negedge Clock) begin
    if (m_ready) begin
      chk("m_instr", Instr_Out, m.instr);
      chk("m_pc", PC_Out, m.pc);
      chk("m_pc4", PC4_Out, m.pc4);
      chk("m_exc", {27'd0, ExcCode_Out}, {27'd0, m.exc});
      chk("m_bd", {31'd0, BD_Out}, {31'd0, m.bd});
      chk("m_valid", {31'd0, Valid_Out}, {31'd0, m.valid});
`ifdef IFID_PERF_EN
      chk("m_stall_cnt", Stall_Cnt, m_stall[31:0]);
      chk("m_flush_cnt", Flush_Cnt, m_flush[31:0]);
`endif
    end
  end

  task automatic drive(input logic en, input logic fl, input logic [31:0] ins,
                       input logic [31:0] pc, input logic err, input logic bd);
    Enable = en; Flush = fl; Instr_In = ins; PC_In = pc; PC4_In = pc + 32'd4;
    IF_Error_In = err; BD_In = bd;
  endtask

  task automatic cycle();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_instr"}, Instr_Out, 32'h0);
    chk({tag, "_pc"}, PC_Out, 32'h00003000);
    chk({tag, "_pc4"}, PC4_Out, 32'h00003004);
    chk({tag, "_exc"}, {27'd0, ExcCode_Out}, 32'd0);
    chk({tag, "_bd"}, {31'd0, BD_Out}, 32'd0);
    chk({tag, "_valid"}, {31'd0, Valid_Out}, 32'd0);
`ifdef IFID_PERF_EN
    chk({tag, "_stall_cnt"}, Stall_Cnt, 32'd0);
    chk({tag, "_flush_cnt"}, Flush_Cnt, 32'd0);
`endif
  endtask

  initial begin
    Reset_n = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1 Reset_n = 1'b0;
    #2 chk_reset_vals("reset");

    // Release between edges with a capture already presented.
    drive(1'b1, 1'b0, 32'h3C010001, 32'h00003000, 1'b0, 1'b0);
    #5 Reset_n = 1'b1;
    cycle();
    chk("cap_instr", Instr_Out, 32'h3C010001);
    chk("cap_pc", PC_Out, 32'h00003000);
    chk("cap_pc4", PC4_Out, 32'h00003004);
    chk("cap_valid", {31'd0, Valid_Out}, 32'd1);
    chk("cap_exc", {27'd0, ExcCode_Out}, 32'd0);

    // Three stalled cycles while the inputs keep moving.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'hDEAD0000 + i, 32'h00005000 + 32'(i * 4), i[0], 1'b1);
      cycle();
      chk("hold_instr", Instr_Out, 32'h3C010001);
      chk("hold_pc", PC_Out, 32'h00003000);
      chk("hold_valid", {31'd0, Valid_Out}, 32'd1);
      chk("hold_bd", {31'd0, BD_Out}, 32'd0);
    end
`ifdef IFID_PERF_EN
    chk("stall_cnt3", Stall_Cnt, 32'd3);
`endif

    // Flush together with a stall: flush wins.
    drive(1'b0, 1'b1, 32'h12345678, 32'h00004180, 1'b1, 1'b1);
    cycle();
    chk("flush_valid", {31'd0, Valid_Out}, 32'd0);
    chk("flush_instr", Instr_Out, 32'h0);
    chk("flush_pc", PC_Out, 32'h00004180);
    chk("flush_pc4", PC4_Out, 32'h00004184);
    chk("flush_bd", {31'd0, BD_Out}, 32'd0);
    chk("flush_exc", {27'd0, ExcCode_Out}, 32'd0);
`ifdef IFID_PERF_EN
    chk("flush_cnt1", Flush_Cnt, 32'd1);
`endif

    // Stall while EMPTY does not count as a stalled cycle.
    drive(1'b0, 1'b0, 32'h11111111, 32'h00006000, 1'b0, 1'b0);
    cycle();
    chk("empty_hold_valid", {31'd0, Valid_Out}, 32'd0);
    chk("empty_hold_pc", PC_Out, 32'h00004180);
`ifdef IFID_PERF_EN
    chk("empty_stall_cnt", Stall_Cnt, 32'd3);
`endif

    // Fetch error: zeroed instruction still travels with its PC.
    drive(1'b1, 1'b0, 32'h0, 32'h00003002, 1'b1, 1'b0);
    cycle();
    chk("err_exc", {27'd0, ExcCode_Out}, 32'd4);
    chk("err_valid", {31'd0, Valid_Out}, 32'd1);
    chk("err_pc", PC_Out, 32'h00003002);
    chk("err_instr", Instr_Out, 32'h0);

    // Flush with Enable=1 also wins over capture.
    drive(1'b1, 1'b1, 32'hCAFEBABE, 32'h00000180, 1'b0, 1'b1);
    cycle();
    chk("flush_en_valid", {31'd0, Valid_Out}, 32'd0);
    chk("flush_en_pc", PC_Out, 32'h00000180);

    // Mixed pattern table; the model process checks each cycle.
    for (int i = 0; i < 12; i++) begin
      drive(i % 3 != 1, i % 5 == 4, 32'hA0000000 | i, 32'h00003100 + 32'(i * 4),
            i % 4 == 3, i[1]);
      cycle();
    end

    // Asynchronous reset between edges while FULL.
    drive(1'b1, 1'b0, 32'h24020005, 32'h00003200, 1'b0, 1'b0);
    cycle();
    chk("pre_rst_valid", {31'd0, Valid_Out}, 32'd1);
    drive(1'b0, 1'b0, 32'h0, 32'h00007000, 1'b0, 1'b0);
    #2 Reset_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    #1 Reset_n = 1'b1;
    drive(1'b1, 1'b0, 32'h8C220000, 32'h00003000, 1'b0, 1'b1);
    cycle();
    chk("bd_capture", {31'd0, BD_Out}, 32'd1);
    chk("bd_instr", Instr_Out, 32'h8C220000);
    chk("bd_valid", {31'd0, Valid_Out}, 32'd1);

    // Reset held across a flush request discards everything.
    drive(1'b1, 1'b1, 32'hFFFFFFFF, 32'h00009000, 1'b1, 1'b1);
    #2 Reset_n = 1'b0;
    cycle();
    chk_reset_vals("rst_over_flush");
    Reset_n = 1'b1;
    drive(1'b1, 1'b0, 32'h00000000, 32'h00003004, 1'b0, 1'b0);
    cycle();
    chk("post_rst_pc", PC_Out, 32'h00003004);
    #6;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_id_reg.md
IF_ID_REG -- requirements
Module: if_id_reg

Interface
REQ-001 Parameter RESET_PC, default 32'h00003000, PC presented while the register holds no instruction after reset.
REQ-002 Clock  input  1  rising-edge clock, shared with the fetch stage PC register.
REQ-003 Reset_n  input  1  asynchronous, active-low reset.
REQ-004 Enable  input  1  1 = capture fetch outputs; 0 = stall, hold contents.
REQ-005 Flush  input  1  1 = replace contents with a bubble (exception entry, eret, mispredict).
REQ-006 Instr_In  input  32  fetched instruction; already forced to 0 by fetch on a fetch error.
REQ-007 PC_In  input  32  PC of Instr_In.
REQ-008 PC4_In  input  32  PC_In+4.
REQ-009 IF_Error_In  input  1  fetch address misaligned or outside the IM window.
REQ-010 BD_In  input  1  Instr_In is in a branch-delay slot, as flagged by ID.
REQ-011 Instr_Out  output  32  instruction delivered to ID.
REQ-012 PC_Out  output  32  PC of Instr_Out.
REQ-013 PC4_Out  output  32  PC_Out+4.
REQ-014 ExcCode_Out  output  5  fetch exception code; 0 = none, 4 = AdEL.
REQ-015 BD_Out  output  1  delay-slot flag of Instr_Out.
REQ-016 Valid_Out  output  1  1 = Instr_Out is a real instruction; 0 = bubble.
REQ-017 Stall_Cnt  output  32  stalled-cycle counter; present only under IFID_PERF_EN.
REQ-018 Flush_Cnt  output  32  flush counter; present only under IFID_PERF_EN.

Function
REQ-019 All outputs shall be registered and update only on the rising edge of Clock or on Reset_n assertion.
REQ-020 Per-edge priority shall be Flush, then Enable=0 (hold), then capture.
REQ-021 Capture shall load Instr_In, PC_In, PC4_In and BD_In, set Valid_Out=1, and set ExcCode_Out=4 if IF_Error_In=1, else 0.
REQ-022 On a fetch error, Instr_Out shall be 32'h00000000 and Valid_Out=1, so the exception propagates with its PC.
REQ-023 Flush shall set Instr_Out=0, ExcCode_Out=0, BD_Out=0 and Valid_Out=0, and shall load PC_Out=PC_In and PC4_Out=PC4_In.
REQ-024 Flush shall win over a simultaneous Enable=0; contents shall be a bubble on the next cycle.
REQ-025 Hold shall keep every output bit unchanged for any number of consecutive stalled cycles.
REQ-026 Latency shall be one cycle from fetch-stage inputs to outputs, with no combinational path from inputs to outputs.
REQ-027 The block shall implement a 2-state machine: EMPTY (Valid_Out=0) and FULL (Valid_Out=1).
REQ-028 Transitions: capture moves to FULL; Flush moves to EMPTY; hold keeps the current state.

Reset
REQ-029 Reset_n=0 shall immediately, without waiting for a clock edge, force the following values: Instr_Out=0, PC_Out=RESET_PC, PC4_Out=RESET_PC+4, ExcCode_Out=0, BD_Out=0, Valid_Out=0, state EMPTY, counters=0.
REQ-030 Reset asserted mid-stall or mid-flush shall override both and discard held contents.
REQ-031 On the first rising edge after Reset_n deasserts, inputs shall be captured normally if Enable=1.

Configuration
REQ-032 Macro IFID_PERF_EN defined: Stall_Cnt shall increment on each edge with Flush=0, Enable=0 and state FULL.
REQ-033 Macro IFID_PERF_EN defined: Flush_Cnt shall increment on each edge with Flush=1.
REQ-034 Macro IFID_PERF_EN defined: both counters shall saturate at 32'hFFFFFFFF and clear only by reset.
REQ-035 Macro IFID_PERF_EN undefined: Stall_Cnt, Flush_Cnt and their logic shall be absent; all other behaviour is identical.

Verification
REQ-036 Reset then Enable=1 with Instr_In=32'h3C010001, PC_In=32'h3000 -> next cycle Instr_Out=32'h3C010001, PC_Out=32'h3000, PC4_Out=32'h3004, Valid_Out=1, ExcCode_Out=0.
REQ-037 Capture, then Enable=0 for 3 cycles while inputs change -> outputs unchanged; with IFID_PERF_EN, Stall_Cnt=3.
REQ-038 Flush=1 and Enable=0 on the same edge with PC_In=32'h4180 -> Valid_Out=0, Instr_Out=0, PC_Out=32'h4180; Flush_Cnt=1.
REQ-039 IF_Error_In=1, Instr_In=0, PC_In=32'h3002 -> ExcCode_Out=4, Valid_Out=1, PC_Out=32'h3002.
REQ-040 Reset_n driven low between clock edges while FULL -> outputs at reset values before the next edge; BD_In=1 on the next capture -> BD_Out=1.
